// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU with operand selection, the ZF/SF/OF condition-code
// register, branch/cmov condition evaluation, and the cmov destination override.
module execute_stage #(
   parameter int W = 64
) (
   input  logic         clk_i,
   input  logic         rst_n_i,      // active-high synchronous reset despite the name
   input  logic [3:0]   E_icode_i,
   input  logic [3:0]   E_ifun_i,
   input  logic [W-1:0] E_valA_i,
   input  logic [W-1:0] E_valB_i,
   input  logic [W-1:0] E_valC_i,
   input  logic [3:0]   E_dstE_i,
   input  logic [3:0]   m_stat_i,
   input  logic [3:0]   W_stat_i,
   output logic [W-1:0] e_valE_o,
   output logic         e_Cnd_o,
   output logic [3:0]   e_dstE_o,
   output logic [2:0]   cc_o
);

   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] A_ADD = 4'h0;
   localparam logic [3:0] A_SUB = 4'h1;
   localparam logic [3:0] A_AND = 4'h2;
   localparam logic [3:0] A_XOR = 4'h3;

   localparam logic [3:0] C_ALWAYS = 4'h0;
   localparam logic [3:0] C_LE     = 4'h1;
   localparam logic [3:0] C_L      = 4'h2;
   localparam logic [3:0] C_E      = 4'h3;
   localparam logic [3:0] C_NE     = 4'h4;
   localparam logic [3:0] C_GE     = 4'h5;
   localparam logic [3:0] C_G      = 4'h6;

   localparam logic [3:0] S_HLT = 4'h2;
   localparam logic [3:0] S_ADR = 4'h3;
   localparam logic [3:0] S_INS = 4'h4;
   localparam logic [3:0] RNONE = 4'hF;

   localparam logic [W-1:0] POS8 = W'(8);
   localparam logic [W-1:0] NEG8 = ~W'(7);   // two's complement -8

   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_fun;
   logic [W-1:0] alu_t;
   logic         new_zf;
   logic         new_sf;
   logic         new_of;
   logic         set_cc;
   logic         m_bad;
   logic         w_bad;
   logic [2:0]   cc;
   logic         zf;
   logic         sf;
   logic         of;

   // Operand and function selection from the instruction code
   always_comb begin
      alu_a = '0;
      alu_b = '0;
      unique case (E_icode_i)
         I_RRMOVQ: alu_a = E_valA_i;
         I_OPQ: begin
            alu_a = E_valA_i;
            alu_b = E_valB_i;
         end
         I_IRMOVQ: alu_a = E_valC_i;
         I_RMMOVQ, I_MRMOVQ: begin
            alu_a = E_valC_i;
            alu_b = E_valB_i;
         end
         I_CALL, I_PUSHQ: begin
            alu_a = NEG8;
            alu_b = E_valB_i;
         end
         I_RET, I_POPQ: begin
            alu_a = POS8;
            alu_b = E_valB_i;
         end
         default: ;
      endcase
      alu_fun = (E_icode_i == I_OPQ) ? E_ifun_i : A_ADD;
   end

   // ALU result and candidate flags; unknown OPQ functions yield a zero result
   always_comb begin
      alu_t  = '0;
      new_of = 1'b0;
      unique case (alu_fun)
         A_ADD: begin
            alu_t  = alu_b + alu_a;
            new_of = (alu_a[W-1] == alu_b[W-1]) && (alu_t[W-1] != alu_a[W-1]);
         end
         A_SUB: begin
            alu_t  = alu_b - alu_a;
            new_of = (alu_a[W-1] != alu_b[W-1]) && (alu_t[W-1] != alu_b[W-1]);
         end
         A_AND: alu_t = alu_b & alu_a;
         A_XOR: alu_t = alu_b ^ alu_a;
         default: ;
      endcase
      new_zf = (alu_t == '0);
      new_sf = alu_t[W-1];
   end

   assign m_bad  = (m_stat_i == S_ADR) || (m_stat_i == S_INS) || (m_stat_i == S_HLT);
   assign w_bad  = (W_stat_i == S_ADR) || (W_stat_i == S_INS) || (W_stat_i == S_HLT);
   assign set_cc = (E_icode_i == I_OPQ) && !m_bad && !w_bad;

   // Condition-code register; reset wins over a same-cycle flag update
   always_ff @(posedge clk_i) begin
      if (rst_n_i) begin
         cc <= 3'b100;
      end else if (set_cc) begin
         cc <= {new_zf, new_sf, new_of};
      end
   end

   assign zf = cc[2];
   assign sf = cc[1];
   assign of = cc[0];

   // Condition evaluation against the registered (pre-update) flags
   always_comb begin
      e_Cnd_o = 1'b0;
      unique case (E_ifun_i)
         C_ALWAYS: e_Cnd_o = 1'b1;
         C_LE:     e_Cnd_o = (sf ^ of) | zf;
         C_L:      e_Cnd_o = sf ^ of;
         C_E:      e_Cnd_o = zf;
         C_NE:     e_Cnd_o = ~zf;
         C_GE:     e_Cnd_o = ~(sf ^ of);
         C_G:      e_Cnd_o = ~(sf ^ of) & ~zf;
         default:  e_Cnd_o = 1'b0;
      endcase
   end

   assign e_valE_o = alu_t;
   assign e_dstE_o = ((E_icode_i == I_RRMOVQ) && !e_Cnd_o) ? RNONE : E_dstE_i;
   assign cc_o     = cc;

endmodule
